// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for the four-digit display driver between two requesters,
// with a minimum hold time per owner and a blanking gap at every owner change.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 5000000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [1:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [3:0]  dot0,
  input  logic [3:0]  dot1,
  input  logic [3:0]  ena0,
  input  logic [3:0]  ena1,
  input  logic [3:0]  crt0,
  input  logic [3:0]  crt1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [3:0]  DIG0,
  output logic [3:0]  DIG1,
  output logic [3:0]  DIG2,
  output logic [3:0]  DIG3,
  output logic [3:0]  DIG_DOT,
  output logic [3:0]  DIG_ENA,
  output logic [3:0]  DIG_CRT
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, BLANK} state_t;

  localparam logic [31:0] HOLD_MAX  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] BLANK_MAX = 32'(BLANK_CYCLES - 1);

  state_t      state, next_state;
  logic [31:0] cnt, cnt_next;
  logic        last, last_next;

  logic        owner;
  logic        own_req, other_req;

  logic [1:0]  gnt_d;
  logic        busy_d;
  logic [15:0] dig_d;
  logic [3:0]  dot_d, ena_d, crt_d;

  assign owner     = (state == GRANT1);
  assign own_req   = owner ? req[1] : req[0];
  assign other_req = owner ? req[0] : req[1];

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      last  <= last_next;
    end
  end

  // A release that coincides with hold expiry takes the same path as a preemption.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    last_next  = last;
    case (state)
      IDLE: begin
        cnt_next = '0;
        case (req)
          2'b01:   next_state = GRANT0;
          2'b10:   next_state = GRANT1;
          2'b11:   next_state = last ? GRANT0 : GRANT1;
          default: next_state = IDLE;
        endcase
      end
      GRANT0, GRANT1: begin
        if (!own_req || (other_req && cnt == HOLD_MAX)) begin
          next_state = BLANK;
          last_next  = owner;
          cnt_next   = '0;
        end else if (cnt != HOLD_MAX) begin
          cnt_next = cnt + 32'd1;
        end
      end
      BLANK: begin
        if (cnt == BLANK_MAX) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output image for the coming cycle, derived from the state held at this edge.
  always_comb begin
    gnt_d  = 2'b00;
    busy_d = 1'b0;
    dig_d  = '0;
    dot_d  = '0;
    ena_d  = '0;
    crt_d  = '0;
    case (state)
      GRANT0: begin
        gnt_d  = 2'b01;
        busy_d = 1'b1;
        dig_d  = val0;
        dot_d  = dot0;
        ena_d  = ena0;
        crt_d  = crt0;
      end
      GRANT1: begin
        gnt_d  = 2'b10;
        busy_d = 1'b1;
        dig_d  = val1;
        dot_d  = dot1;
        ena_d  = ena1;
        crt_d  = crt1;
      end
      BLANK:   busy_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      gnt     <= 2'b00;
      busy    <= 1'b0;
      DIG0    <= '0;
      DIG1    <= '0;
      DIG2    <= '0;
      DIG3    <= '0;
      DIG_DOT <= '0;
      DIG_ENA <= '0;
      DIG_CRT <= '0;
    end else begin
      gnt     <= gnt_d;
      busy    <= busy_d;
      DIG0    <= dig_d[3:0];
      DIG1    <= dig_d[7:4];
      DIG2    <= dig_d[11:8];
      DIG3    <= dig_d[15:12];
      DIG_DOT <= dot_d;
      DIG_ENA <= ena_d;
      DIG_CRT <= crt_d;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: directed per-cycle vectors push hand-derived
// expected outputs; a monitor pops one entry after every clock edge and compares.
module tb_seg_display_arbiter;

  localparam logic [15:0] VAL1_FIX = 16'hABCD;
  localparam logic [3:0]  DOT0_FIX = 4'h5, ENA0_FIX = 4'hF, CRT0_FIX = 4'hA;
  localparam logic [3:0]  DOT1_FIX = 4'hC, ENA1_FIX = 4'h3, CRT1_FIX = 4'h6;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        busy;
    logic [15:0] dig;
    logic [3:0]  dot;
    logic [3:0]  ena;
    logic [3:0]  crt;
  } exp_t;

  logic        clk = 1'b0;
  logic        RSTn;
  logic [1:0]  req;
  logic [15:0] val0, val1;
  logic [3:0]  dot0, dot1, ena0, ena1, crt0, crt1;
  logic [1:0]  gnt;
  logic        busy;
  logic [3:0]  DIG0, DIG1, DIG2, DIG3, DIG_DOT, DIG_ENA, DIG_CRT;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  string name_q[$];

  seg_display_arbiter #(.HOLD_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .RSTn(RSTn), .req(req),
    .val0(val0), .val1(val1), .dot0(dot0), .dot1(dot1),
    .ena0(ena0), .ena1(ena1), .crt0(crt0), .crt1(crt1),
    .gnt(gnt), .busy(busy),
    .DIG0(DIG0), .DIG1(DIG1), .DIG2(DIG2), .DIG3(DIG3),
    .DIG_DOT(DIG_DOT), .DIG_ENA(DIG_ENA), .DIG_CRT(DIG_CRT)
  );

  always #5 clk = ~clk;

  function automatic exp_t zero_exp();
    return '0;
  endfunction

  function automatic exp_t blank_exp();
    exp_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t own0_exp(input logic [15:0] v);
    return '{gnt: 2'b01, busy: 1'b1, dig: v, dot: DOT0_FIX, ena: ENA0_FIX, crt: CRT0_FIX};
  endfunction

  function automatic exp_t own1_exp();
    return '{gnt: 2'b10, busy: 1'b1, dig: VAL1_FIX, dot: DOT1_FIX, ena: ENA1_FIX, crt: CRT1_FIX};
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act = '{gnt: gnt, busy: busy, dig: {DIG3, DIG2, DIG1, DIG0},
            dot: DIG_DOT, ena: DIG_ENA, crt: DIG_CRT};
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("[TB] FAIL %s: got gnt=%b busy=%b dig=%h dot=%h ena=%h crt=%h, want gnt=%b busy=%b dig=%h dot=%h ena=%h crt=%h",
               name, act.gnt, act.busy, act.dig, act.dot, act.ena, act.crt,
               e.gnt, e.busy, e.dig, e.dot, e.ena, e.crt);
    end
  endtask

  // Inputs are driven 2 time units after an edge; the expectation covers the output after the next edge.
  task automatic applyStimulus(input string name, input logic [1:0] r, input exp_t e);
    req = r;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(n, e);
      end
    end
  end

  initial begin : stimulus
    RSTn = 1'b1;
    req  = 2'b00;
    val0 = 16'h1234; dot0 = DOT0_FIX; ena0 = ENA0_FIX; crt0 = CRT0_FIX;
    val1 = VAL1_FIX; dot1 = DOT1_FIX; ena1 = ENA1_FIX; crt1 = CRT1_FIX;
    #2 RSTn = 1'b0;
    #1 checkOutput("reset_state", zero_exp());
    @(posedge clk);
    #2 RSTn = 1'b1;

    applyStimulus("req0_first_edge", 2'b01, zero_exp());
    applyStimulus("req0_granted", 2'b01, own0_exp(16'h1234));

    // Contention while owner 0 holds; owner data moves each cycle, non-owner inputs are noise.
    for (int i = 0; i < 7; i++) begin
      val0 = 16'h2345 + 16'(i * 16'h1111);
      val1 = 16'($urandom);
      ena1 = 4'($urandom);
      dot1 = 4'($urandom);
      crt1 = 4'($urandom);
      applyStimulus("hold_owner0", 2'b11, own0_exp(val0));
    end
    val1 = VAL1_FIX; dot1 = DOT1_FIX; ena1 = ENA1_FIX; crt1 = CRT1_FIX;
    applyStimulus("preempt_blank_a", 2'b11, blank_exp());
    applyStimulus("preempt_blank_b", 2'b11, blank_exp());
    applyStimulus("preempt_idle", 2'b11, zero_exp());
    applyStimulus("preempt_grant1", 2'b11, own1_exp());

    applyStimulus("owner1_keep_a", 2'b10, own1_exp());
    applyStimulus("owner1_keep_b", 2'b10, own1_exp());
    applyStimulus("owner1_release_edge", 2'b00, own1_exp());
    applyStimulus("release_blank_a", 2'b00, blank_exp());
    applyStimulus("release_blank_b", 2'b00, blank_exp());
    applyStimulus("release_idle_a", 2'b00, zero_exp());
    applyStimulus("release_idle_b", 2'b00, zero_exp());

    applyStimulus("req1_first_edge", 2'b10, zero_exp());
    applyStimulus("req1_granted", 2'b10, own1_exp());
    RSTn = 1'b0;
    #1 checkOutput("async_reset_mid_grant1", zero_exp());
    applyStimulus("held_in_reset", 2'b11, zero_exp());
    RSTn = 1'b1;

    val0 = 16'h1234;
    applyStimulus("both_after_reset_edge", 2'b11, zero_exp());
    applyStimulus("both_after_reset_gnt0", 2'b11, own0_exp(16'h1234));
    applyStimulus("owner0_release_edge", 2'b10, own0_exp(16'h1234));
    applyStimulus("rr_blank_a", 2'b11, blank_exp());
    applyStimulus("rr_blank_b", 2'b11, blank_exp());
    applyStimulus("rr_idle", 2'b11, zero_exp());
    applyStimulus("rr_grant1", 2'b11, own1_exp());
    applyStimulus("final_release_edge", 2'b00, own1_exp());
    applyStimulus("final_blank", 2'b00, blank_exp());

    repeat (4) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
